mem_access_fsm: RTL and testbench

MEM_ACCESS_FSM -- requirements
Module: mem_access_fsm

---
 rtl/mem_access_fsm.sv | 149 ++++++++++++++
 tb/tb_mem_access_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_fsm.sv
// Memory access controller: arbitrates N_CH requesters round-robin, then runs
// a fixed SETUP / ACCESS(WAIT_CYC) / DONE sequence for the winning channel.
// All outputs come straight from flops; sel/op only affect next-state logic.
module mem_access_fsm #(
  parameter int N_CH     = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sel,
  input  logic [N_CH-1:0] op,
  output logic [N_CH-1:0] grant,
  output logic [2:0]      gnt_id,
  output logic            rw,
  output logic            we,
  output logic            oe,
  output logic            valid,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [3:0]      cnt_q, cnt_n;
  logic [2:0]      last_q, last_n;
  logic [N_CH-1:0] grant_n;
  logic [2:0]      id_n;
  logic            rw_n, we_n, oe_n, valid_n, busy_n;

  logic            win_found;
  logic [2:0]      win_idx;
  logic [N_CH-1:0] win_onehot;
  logic            win_op;

  // Round-robin pick: first look above last_granted, then wrap from channel 0.
  // The second pass also covers last_granted itself when it is the only requester.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_op     = 1'b0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!win_found && (j > 32'(last_q)) && (((sel >> j) & N_CH'(1)) != '0)) begin
        win_found  = 1'b1;
        win_idx    = 3'(j);
        win_onehot = N_CH'(1) << j;
        win_op     = ((op >> j) & N_CH'(1)) != '0;
      end
    end
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!win_found && (((sel >> j) & N_CH'(1)) != '0)) begin
        win_found  = 1'b1;
        win_idx    = 3'(j);
        win_onehot = N_CH'(1) << j;
        win_op     = ((op >> j) & N_CH'(1)) != '0;
      end
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    last_n  = last_q;
    grant_n = grant;
    id_n    = gnt_id;
    rw_n    = rw;
    we_n    = 1'b0;
    oe_n    = 1'b0;
    valid_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_n = '0;
        id_n    = '0;
        rw_n    = 1'b0;
        if (win_found) begin
          state_n = SETUP;
          grant_n = win_onehot;
          id_n    = win_idx;
          rw_n    = win_op;
          last_n  = win_idx;
          cnt_n   = 4'(WAIT_CYC);
        end
      end
      SETUP: begin
        state_n = ACCESS;
        we_n    = rw;
        oe_n    = ~rw;
      end
      ACCESS: begin
        if (cnt_q <= 4'd1) begin
          state_n = DONE;
          cnt_n   = '0;
          valid_n = 1'b1;
        end else begin
          cnt_n = cnt_q - 4'd1;
          we_n  = rw;
          oe_n  = ~rw;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        id_n    = '0;
        rw_n    = 1'b0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        id_n    = '0;
        rw_n    = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, counter, arbitration pointer and all outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 3'(N_CH - 1);
      grant   <= '0;
      gnt_id  <= '0;
      rw      <= 1'b0;
      we      <= 1'b0;
      oe      <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      last_q  <= last_n;
      grant   <= grant_n;
      gnt_id  <= id_n;
      rw      <= rw_n;
      we      <= we_n;
      oe      <= oe_n;
      valid   <= valid_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_access_fsm.sv
// Bench for mem_access_fsm (N_CH=2, WAIT_CYC=2): transaction-timeline model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_access_fsm;

  localparam int N_CH     = 2;
  localparam int WAIT_CYC = 2;
  localparam int OCC      = WAIT_CYC + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] sel = '0;
  logic [N_CH-1:0] op  = '0;
  logic [N_CH-1:0] grant;
  logic [2:0]      gnt_id;
  logic            rw, we, oe, valid, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_fsm #(.N_CH(N_CH), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .sel(sel), .op(op),
    .grant(grant), .gnt_id(gnt_id), .rw(rw), .we(we), .oe(oe),
    .valid(valid), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_pos = 0 when idle, else 1-based cycle position inside a transaction
  // of OCC cycles (1 = setup, 2..WAIT_CYC+1 = access, OCC = done).
  int m_pos  = 0;
  int m_ch   = 0;
  int m_op   = 0;
  int m_last = N_CH - 1;
  bit m_live = 1'b0;
  bit m_hit;

  always @(posedge clk) begin
    if (rst) begin
      m_pos  = 0;
      m_last = N_CH - 1;
      m_live = 1'b1;
    end else if (m_pos == 0) begin
      m_hit = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
        if (!m_hit && (((sel >> ((m_last + k) % N_CH)) & 1) != 0)) begin
          m_hit  = 1'b1;
          m_ch   = (m_last + k) % N_CH;
          m_op   = (((op >> m_ch) & 1) != 0) ? 1 : 0;
          m_last = m_ch;
          m_pos  = 1;
        end
      end
    end else if (m_pos == OCC) begin
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  end

  // Per-cycle comparison against the model plus structural invariants.
  always @(negedge clk) begin
    if (m_live) begin
      check("busy",   int'(busy),   (m_pos != 0) ? 1 : 0);
      check("grant",  int'(grant),  (m_pos != 0) ? (1 << m_ch) : 0);
      check("gnt_id", int'(gnt_id), (m_pos != 0) ? m_ch : 0);
      check("rw",     int'(rw),     (m_pos != 0) ? m_op : 0);
      check("we",     int'(we),     (m_pos >= 2 && m_pos <= WAIT_CYC + 1 && m_op == 1) ? 1 : 0);
      check("oe",     int'(oe),     (m_pos >= 2 && m_pos <= WAIT_CYC + 1 && m_op == 0) ? 1 : 0);
      check("valid",  int'(valid),  (m_pos == OCC) ? 1 : 0);
      check("we_oe_excl",    int'(we & oe), 0);
      check("grant_onehot0", int'($onehot0(grant)), 1);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int vcnt, wecnt, oecnt, gcnt;
    int prev_g;
    int gseq[$];
    int vq[$];

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", int'(grant), 0);
    check("rst_busy",  int'(busy),  0);
    check("rst_valid", int'(valid), 0);
    check("rst_weoe",  int'({we, oe}), 0);
    rst = 1'b0;

    // Read from ch0 (sel held one cycle)
    sel = 2'b01; op = 2'b00;
    vcnt = 0; wecnt = 0; oecnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("rd_grant", int'(grant), 1);
        check("rd_rw", int'(rw), 0);
        check("rd_setup_oe", int'(oe), 0);
        sel = '0;
      end
      if (i == 4) check("rd_valid_at4", int'(valid), 1);
      if (i == 5) check("rd_idle_after", int'(busy), 0);
      vcnt += int'(valid); wecnt += int'(we); oecnt += int'(oe);
    end
    check("rd_valid_count", vcnt, 1);
    check("rd_oe_count", oecnt, 2);
    check("rd_we_count", wecnt, 0);

    // Write from ch1
    sel = 2'b10; op = 2'b10;
    vcnt = 0; wecnt = 0; oecnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("wr_grant", int'(grant), 2);
        check("wr_gnt_id", int'(gnt_id), 1);
        check("wr_rw", int'(rw), 1);
        sel = '0; op = '0;
      end
      vcnt += int'(valid); wecnt += int'(we); oecnt += int'(oe);
    end
    check("wr_valid_count", vcnt, 1);
    check("wr_we_count", wecnt, 2);
    check("wr_oe_count", oecnt, 0);

    // Contention from reset: grants alternate, period OCC + 1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sel = 2'b11; op = 2'b00;
    prev_g = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (grant != '0 && prev_g == 0) gseq.push_back(int'(grant));
      if (valid) vq.push_back(i);
      prev_g = int'(grant);
    end
    sel = '0;
    check("cont_grants", gseq.size(), 4);
    if (gseq.size() >= 3) begin
      check("cont_g0", gseq[0], 1);
      check("cont_g1", gseq[1], 2);
      check("cont_g2", gseq[2], 1);
    end
    check("cont_valids", vq.size(), 3);
    if (vq.size() >= 2) check("cont_valid_gap", vq[1] - vq[0], 5);
    wait_idle();

    // Request withdrawn after one cycle
    @(negedge clk);
    sel = 2'b01; op = 2'b00;
    vcnt = 0; gcnt = 0; prev_g = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) sel = '0;
      if (grant != '0 && prev_g == 0) gcnt++;
      prev_g = int'(grant);
      vcnt += int'(valid);
    end
    check("wd_valid_count", vcnt, 1);
    check("wd_grant_count", gcnt, 1);

    // Reset while in ACCESS
    sel = 2'b01; op = 2'b00;
    @(negedge clk);
    sel = '0;
    @(negedge clk);
    check("ra_in_access", int'(oe), 1);
    rst = 1'b1;
    @(negedge clk);
    check("ra_outputs", int'({grant, gnt_id, rw, we, oe, valid, busy}), 0);
    rst = 1'b0; sel = 2'b11;
    @(negedge clk);
    check("ra_regrant", int'(grant), 1);
    check("ra_regrant_id", int'(gnt_id), 0);
    sel = '0;
    wait_idle();

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sel = 2'($urandom_range(0, 3));
      op  = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst = 1'b0; sel = '0; op = '0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
